// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and MEM stages.
// Data accesses win; burstCount bounds how long a fetch miss can be starved.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetchRequest,
    input  logic [ADDR_WIDTH-1:0] fetchAddress,
    output logic [DATA_WIDTH-1:0] fetchData,
    output logic                  fetchSuccess,
    input  logic                  dataRead,
    input  logic                  dataWrite,
    input  logic [ADDR_WIDTH-1:0] dataAddress,
    input  logic [DATA_WIDTH-1:0] dataWriteData,
    output logic [DATA_WIDTH-1:0] dataReadData,
    output logic                  dataDone,
    output logic                  memRequest,
    output logic                  memWriteEnable,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0] memWriteData,
    input  logic [DATA_WIDTH-1:0] memReadData,
    input  logic                  memReady
);

    localparam int CW = $clog2(MAX_DATA_BURST + 2);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_DATA_BURST);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] DATA_BUSY  = 2'd1;
    localparam logic [1:0] FETCH_BUSY = 2'd2;

    logic [1:0]            state;
    logic [CW-1:0]         burstCount;
    logic                  bufValid;
    logic [ADDR_WIDTH-1:0] bufTag;
    logic [DATA_WIDTH-1:0] bufData;
    logic [ADDR_WIDTH-1:0] pendingTag;

    logic dataPending;
    logic fetchMiss;
    logic dataGrant;

    assign fetchSuccess = bufValid && (bufTag == fetchAddress);
    assign fetchData    = bufData;

    // A request still high in the dataDone cycle belongs to the access just finished.
    assign dataPending = (dataRead || dataWrite) && !dataDone;
    assign fetchMiss   = fetchRequest && !fetchSuccess;
    assign dataGrant   = dataPending && (!fetchMiss || (burstCount < BURST_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            burstCount     <= '0;
            bufValid       <= 1'b0;
            bufTag         <= '0;
            bufData        <= '0;
            pendingTag     <= '0;
            dataDone       <= 1'b0;
            dataReadData   <= '0;
            memRequest     <= 1'b0;
            memWriteEnable <= 1'b0;
            memAddress     <= '0;
            memWriteData   <= '0;
        end else begin
            dataDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (dataGrant) begin
                        state          <= DATA_BUSY;
                        memRequest     <= 1'b1;
                        memWriteEnable <= dataWrite;
                        memAddress     <= dataAddress;
                        memWriteData   <= dataWriteData;
                        if (!fetchMiss) begin
                            burstCount <= '0;
                        end else if (burstCount != BURST_MAX) begin
                            burstCount <= burstCount + 1'b1;
                        end
                    end else if (fetchMiss) begin
                        state          <= FETCH_BUSY;
                        memRequest     <= 1'b1;
                        memWriteEnable <= 1'b0;
                        memAddress     <= fetchAddress;
                        memWriteData   <= '0;
                        pendingTag     <= fetchAddress;
                        burstCount     <= '0;
                    end else begin
                        burstCount <= '0;
                    end
                end
                DATA_BUSY: begin
                    if (memReady) begin
                        state          <= IDLE;
                        dataDone       <= 1'b1;
                        memRequest     <= 1'b0;
                        memWriteEnable <= 1'b0;
                        memAddress     <= '0;
                        memWriteData   <= '0;
                        if (!memWriteEnable) begin
                            dataReadData <= memReadData;
                        end else if (bufValid && (bufTag == memAddress)) begin
                            bufValid <= 1'b0;
                        end
                    end
                end
                FETCH_BUSY: begin
                    // The line fills under its original tag even if the PC moved.
                    if (memReady) begin
                        state          <= IDLE;
                        bufValid       <= 1'b1;
                        bufTag         <= pendingTag;
                        bufData        <= memReadData;
                        memRequest     <= 1'b0;
                        memWriteEnable <= 1'b0;
                        memAddress     <= '0;
                        memWriteData   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
